// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller and its datapath muxes.
// The TRAP state exists only when ILLEGAL_TRAP_EN is defined.
package cpu_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_READDATA  = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALRLINK,
        S_LUI
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    typedef enum logic [3:0] {
        CLS_LOAD,
        CLS_STORE,
        CLS_RTYPE,
        CLS_ITYPE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_ILLEGAL
    } instr_class_t;

    // Immediate format is a pure function of the opcode, independent of FSM state.
    function automatic logic [2:0] imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            OP_LUI:    return IMM_U;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational opcode decode: immediate format, instruction class, illegal flag.
module mc_opcode_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [2:0]  imm_src,
    output logic [3:0]  cls,
    output logic        illegal
);

    logic [6:0] opcode;
    logic       unused_bits;

    assign opcode      = instr_i[6:0];
    assign imm_src     = imm_src_of(opcode);
    assign unused_bits = ^{instr_i[31:15], instr_i[12:7]};

    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OP_LOAD:   cls = CLS_LOAD;
            OP_STORE:  cls = CLS_STORE;
            OP_RTYPE:  cls = CLS_RTYPE;
            OP_ITYPE:  cls = CLS_ITYPE;
            // only beq/bne are implemented
            OP_BRANCH: cls = (instr_i[14:13] == 2'b00) ? CLS_BRANCH : CLS_ILLEGAL;
            OP_JAL:    cls = CLS_JAL;
            OP_JALR:   cls = CLS_JALR;
            OP_LUI:    cls = CLS_LUI;
            default:   cls = CLS_ILLEGAL;
        endcase
    end

    assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle main controller: fetch/decode/execute/memory/writeback sequencing.
// ILLEGAL_TRAP_EN: illegal instructions park the FSM in TRAP with a sticky flag.
module mc_control_fsm
    import cpu_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic [2:0]  ImmSrc_o,
    output logic [1:0]  ALUSrcA_o,
    output logic [1:0]  ALUSrcB_o,
    output logic [1:0]  ALUOp_o,
    output logic [1:0]  ResultSrc_o,
    output logic        AdrSrc_o,
    output logic        MemRead_o,
    output logic        MemWrite_o,
    output logic        IRWrite_o,
    output logic        PCWrite_o,
    output logic        RegWrite_o,
    output logic        illegal_o
);

    state_t     state, state_nxt;
    logic [2:0] imm_src;
    logic [3:0] cls;
    logic       dec_illegal;
    logic       mem_read, mem_write, ir_write, pc_write, reg_write;

    mc_opcode_decode u_dec (
        .instr_i (instr_i),
        .imm_src (imm_src),
        .cls     (cls),
        .illegal (dec_illegal)
    );

    assign ImmSrc_o = imm_src;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        ALUSrcA_o   = SRCA_PC;
        ALUSrcB_o   = SRCB_RS2;
        ALUOp_o     = ALUOP_ADD;
        ResultSrc_o = RES_ALUOUT;
        AdrSrc_o    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read    = 1'b1;
                ALUSrcB_o   = SRCB_FOUR;
                ResultSrc_o = RES_ALURESULT;
                if (mem_ready_i) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                // ALUOut captures OldPC+imm: the branch/JAL target
                ALUSrcA_o = SRCA_OLDPC;
                ALUSrcB_o = SRCB_IMM;
                case (cls)
                    CLS_LOAD, CLS_STORE: state_nxt = S_MEMADR;
                    CLS_RTYPE:           state_nxt = S_EXECR;
                    CLS_ITYPE:           state_nxt = S_EXECI;
                    CLS_BRANCH:          state_nxt = S_BRANCH;
                    CLS_JAL:             state_nxt = S_JAL;
                    CLS_JALR:            state_nxt = S_JALR;
                    CLS_LUI:             state_nxt = S_LUI;
`ifdef ILLEGAL_TRAP_EN
                    default:             state_nxt = S_TRAP;
`else
                    default:             state_nxt = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ALUSrcA_o = SRCA_RS1;
                ALUSrcB_o = SRCB_IMM;
                state_nxt = (cls == CLS_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                AdrSrc_o = 1'b1;
                if (mem_ready_i) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc_o = RES_READDATA;
                reg_write   = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                AdrSrc_o  = 1'b1;
                if (mem_ready_i) state_nxt = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA_o = SRCA_RS1;
                ALUSrcB_o = SRCB_RS2;
                ALUOp_o   = ALUOP_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA_o = SRCA_RS1;
                ALUSrcB_o = SRCB_IMM;
                ALUOp_o   = ALUOP_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc_o = RES_ALUOUT;
                reg_write   = 1'b1;
                state_nxt   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA_o = SRCA_RS1;
                ALUSrcB_o = SRCB_RS2;
                ALUOp_o   = ALUOP_SUB;
                // funct3[0] flips beq into bne
                pc_write  = zero_i ^ instr_i[12];
                state_nxt = S_FETCH;
            end
            S_JAL, S_JALRLINK: begin
                ALUSrcA_o = SRCA_OLDPC;
                ALUSrcB_o = SRCB_FOUR;
                pc_write  = 1'b1;
                state_nxt = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA_o = SRCA_RS1;
                ALUSrcB_o = SRCB_IMM;
                state_nxt = S_JALRLINK;
            end
            S_LUI: begin
                ALUSrcA_o = SRCA_ZERO;
                ALUSrcB_o = SRCB_IMM;
                state_nxt = S_ALUWB;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: state_nxt = S_TRAP;
`endif
            default: state_nxt = S_FETCH;
        endcase
    end

    // Strobes drop in the reset cycle itself so an abandoned access is withdrawn at once.
    assign MemRead_o  = mem_read  & ~rst_i;
    assign MemWrite_o = mem_write & ~rst_i;
    assign IRWrite_o  = ir_write  & ~rst_i;
    assign PCWrite_o  = pc_write  & ~rst_i;
    assign RegWrite_o = reg_write & ~rst_i;

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)                              illegal_q <= 1'b0;
        else if (state == S_DECODE && dec_illegal) illegal_q <= 1'b1;
    end

    assign illegal_o = illegal_q;
`else
    logic unused_illegal;

    assign unused_illegal = dec_illegal;
    assign illegal_o      = 1'b0;
`endif

endmodule
